key_pulse_gen: RTL and testbench

- Multi-channel successor to the single-key press detector: N independent push-button channels.
- Each channel has a programmable debounce filter and a one-cycle press pulse.
- Optional per-channel typematic auto-repeat (pulse re-fires while the key is held).
- Sits between raw board keys and game-control logic (e.g. copter lift, menu select); all outputs are registered in the clk domain.

---
 rtl/key_pulse_gen.sv | 122 ++++++++++++
 tb/tb_key_pulse_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: N-channel key debounce, one-cycle press pulse, typematic repeat.
// Define KEY_PULSE_GEN_SYNC_EN to insert a 2-flop synchronizer ahead of debounce.
module key_pulse_gen #(
   parameter int N             = 4,
   parameter int DEBOUNCE      = 4,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in,
   input  logic [N-1:0] rep_en,
   output logic [N-1:0] press,
   output logic [N-1:0] held
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
   localparam logic [RW-1:0] R_SAT   = RW'(RMAX - 1);

   logic [N-1:0]  key_s;

`ifdef KEY_PULSE_GEN_SYNC_EN
   logic [N-1:0]  sync1_q, sync1_d;
   logic [N-1:0]  sync2_q, sync2_d;

   always_comb begin
      sync1_d = in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign key_s = sync2_q;
`else
   assign key_s = in;
`endif

   logic [N-1:0]  db_q, db_d;
   logic [N-1:0]  rphase_q, rphase_d;
   logic [N-1:0]  press_q, press_d;
   logic [N-1:0]  held_q, held_d;
   logic [DW-1:0] dcnt_q [N];
   logic [DW-1:0] dcnt_d [N];
   logic [RW-1:0] rcnt_q [N];
   logic [RW-1:0] rcnt_d [N];

   always_comb begin
      db_d     = db_q;
      rphase_d = rphase_q;
      press_d  = '0;
      held_d   = held_q;
      for (int i = 0; i < N; i++) begin
         dcnt_d[i] = dcnt_q[i];
         rcnt_d[i] = rcnt_q[i];

         if (key_s[i] == db_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DB_LAST) begin
            db_d[i]   = key_s[i];
            dcnt_d[i] = '0;
         end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
         end

         held_d[i]  = db_d[i];
         press_d[i] = db_d[i] & ~db_q[i];

         // A release accepted this edge also cancels any repeat due now.
         if (!db_q[i] || !db_d[i] || !rep_en[i]) begin
            rcnt_d[i]   = '0;
            rphase_d[i] = 1'b0;
         end else if (rcnt_q[i] == (rphase_q[i] ? RP_LAST : RD_LAST)) begin
            press_d[i]  = 1'b1;
            rcnt_d[i]   = '0;
            rphase_d[i] = 1'b1;
         end else if (rcnt_q[i] != R_SAT) begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         db_q     <= '0;
         rphase_q <= '0;
         press_q  <= '0;
         held_q   <= '0;
         for (int i = 0; i < N; i++) begin
            dcnt_q[i] <= '0;
            rcnt_q[i] <= '0;
         end
      end else begin
         db_q     <= db_d;
         rphase_q <= rphase_d;
         press_q  <= press_d;
         held_q   <= held_d;
         for (int i = 0; i < N; i++) begin
            dcnt_q[i] <= dcnt_d[i];
            rcnt_q[i] <= rcnt_d[i];
         end
      end
   end

   assign press = press_q;
   assign held  = held_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: scenario tasks plus a window/run-length reference model.
// Honors KEY_PULSE_GEN_SYNC_EN by adding two cycles of input latency.
module tb_key_pulse_gen;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int RD = 16;
   localparam int RP = 4;
`ifdef KEY_PULSE_GEN_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif
   // edge index of the first pulse when a key rises before edge 0
   localparam int L = D + SL - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] in = '0;
   logic [N-1:0] rep_en = '0;
   logic [N-1:0] press;
   logic [N-1:0] held;

   int errs = 0;
   int checks = 0;

   key_pulse_gen #(
      .N(N), .DEBOUNCE(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .in(in), .rep_en(rep_en),
      .press(press), .held(held)
   );

   always #5 clk = ~clk;

   // Reference: a level is accepted once the last D samples all oppose it;
   // repeats fire at run lengths RD, RD+RP, ... of held-and-enabled edges.
   logic [N-1:0] m_press = '0;
   logic [N-1:0] m_held = '0;
   logic [N-1:0] m_s1 = '0;
   logic [N-1:0] m_s2 = '0;
   bit           win [N][$];
   int           run [N];

   always @(posedge clk) begin
      logic [N-1:0] smp;
      if (!reset) begin
         m_press = '0;
         m_held = '0;
         m_s1 = '0;
         m_s2 = '0;
         for (int i = 0; i < N; i++) begin
            win[i].delete();
            run[i] = 0;
         end
      end else begin
`ifdef KEY_PULSE_GEN_SYNC_EN
         smp = m_s2;
         m_s2 = m_s1;
         m_s1 = in;
`else
         smp = in;
`endif
         for (int i = 0; i < N; i++) begin
            bit nd, p, flip;
            win[i].push_back(smp[i]);
            if (win[i].size() > D) void'(win[i].pop_front());
            flip = (win[i].size() == D);
            for (int j = 0; j < win[i].size(); j++)
               if (win[i][j] == m_held[i]) flip = 1'b0;
            nd = flip ? ~m_held[i] : m_held[i];
            p = nd & ~m_held[i];
            if (m_held[i] && nd && rep_en[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == RD || (run[i] > RD && (run[i] - RD) % RP == 0))
               p = 1'b1;
            m_held[i] = nd;
            m_press[i] = p;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic settle();
      in = '0;
      rep_en = '0;
      reset = 1'b1;
      for (int c = 0; c < D + SL + 3; c++) tick();
   endtask

   task automatic test_reset();
      logic [N-1:0] ex;
      reset = 1'b0;
      in = '1;
      rep_en = '0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (press !== '0 || held !== '0) begin
            errs++;
            $display("FAIL reset_hold c=%0d press=%b held=%b want 0000/0000",
                     c, press, held);
         end
      end
      reset = 1'b1;
      for (int e = 0; e <= L + 2; e++) begin
         tick();
         ex = (e == L) ? '1 : '0;
         checks++;
         if (press !== ex) begin
            errs++;
            $display("FAIL reset_release e=%0d press=%b want %b", e, press, ex);
         end
         checks++;
         if ({press, held} !== {m_press, m_held}) begin
            errs++;
            $display("FAIL reset_model e=%0d got %b/%b want %b/%b",
                     e, press, held, m_press, m_held);
         end
      end
      settle();
   endtask

   task automatic test_clean_press();
      bit ep, eh;
      rep_en = '0;
      for (int e = 0; e < 18; e++) begin
         in = {3'b000, (e < 10)};
         tick();
         ep = (e == L);
         eh = (e >= L) && (e <= 10 + L - 1);
         checks++;
         if (press[0] !== ep || held[0] !== eh) begin
            errs++;
            $display("FAIL clean_press e=%0d press0=%b held0=%b want %b/%b",
                     e, press[0], held[0], ep, eh);
         end
         checks++;
         if ({press, held} !== {m_press, m_held}) begin
            errs++;
            $display("FAIL clean_model e=%0d got %b/%b want %b/%b",
                     e, press, held, m_press, m_held);
         end
      end
      settle();
   endtask

   task automatic test_bounce();
      rep_en = '0;
      for (int e = 0; e < 12; e++) begin
         in = {2'b00, (e < 6) && (e % 2 == 0), 1'b0};
         tick();
         checks++;
         if (press[1] !== 1'b0 || held[1] !== 1'b0) begin
            errs++;
            $display("FAIL bounce e=%0d press1=%b held1=%b want 0/0",
                     e, press[1], held[1]);
         end
         checks++;
         if ({press, held} !== {m_press, m_held}) begin
            errs++;
            $display("FAIL bounce_model e=%0d got %b/%b want %b/%b",
                     e, press, held, m_press, m_held);
         end
      end
      settle();
   endtask

   task automatic test_auto_repeat(input int drop);
      bit ep;
      for (int e = 0; e < 40; e++) begin
         in = 4'b0100;
         rep_en = {1'b0, (e < drop), 2'b00};
         tick();
         ep = (e == L) ||
              (e >= L + RD && (e - L - RD) % RP == 0 && e < drop);
         checks++;
         if (press[2] !== ep) begin
            errs++;
            $display("FAIL auto_repeat drop=%0d e=%0d press2=%b want %b",
                     drop, e, press[2], ep);
         end
         checks++;
         if ({press, held} !== {m_press, m_held}) begin
            errs++;
            $display("FAIL repeat_model e=%0d got %b/%b want %b/%b",
                     e, press, held, m_press, m_held);
         end
      end
      settle();
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] ex;
      rep_en = '0;
      in = 4'b1001;
      for (int e = 0; e < L + 4; e++) begin
         tick();
         ex = (e == L) ? 4'b1001 : 4'b0000;
         checks++;
         if (press !== ex) begin
            errs++;
            $display("FAIL simultaneous e=%0d press=%b want %b", e, press, ex);
         end
      end
      settle();
   endtask

   task automatic test_reset_mid_repeat();
      bit ep;
      int f;
      f = 22 + L;
      in = 4'b0100;
      rep_en = 4'b0100;
      for (int e = 0; e < 46; e++) begin
         reset = (e != 21);
         tick();
         ep = (e == L) || (e == L + RD) || (e == f) ||
              (e >= f + RD && (e - f - RD) % RP == 0);
         checks++;
         if (press[2] !== ep) begin
            errs++;
            $display("FAIL mid_reset e=%0d press2=%b want %b", e, press[2], ep);
         end
         if (e == 21) begin
            checks++;
            if (press !== '0 || held !== '0) begin
               errs++;
               $display("FAIL mid_reset_clear press=%b held=%b want 0/0",
                        press, held);
            end
         end
         checks++;
         if ({press, held} !== {m_press, m_held}) begin
            errs++;
            $display("FAIL mid_model e=%0d got %b/%b want %b/%b",
                     e, press, held, m_press, m_held);
         end
      end
      reset = 1'b1;
      settle();
   endtask

   task automatic test_random();
      for (int e = 0; e < 1500; e++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3 + 12 * i) == 0) in[i] = ~in[i];
            if ($urandom_range(0, 59) == 0) rep_en[i] = ~rep_en[i];
         end
         reset = ($urandom_range(0, 199) != 0);
         tick();
         checks++;
         if ({press, held} !== {m_press, m_held}) begin
            errs++;
            $display("FAIL random e=%0d in=%b rep=%b got %b/%b want %b/%b",
                     e, in, rep_en, press, held, m_press, m_held);
         end
      end
      settle();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat(1000);
      test_auto_repeat(25);
      test_simultaneous();
      test_reset_mid_repeat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
